hci_mem_bank_responder: RTL and testbench

HCI_MEM_BANK_RESPONDER -- requirements
Module: hci_mem_bank_responder

---
 rtl/hci_mem_bank_responder.sv | 122 ++++++++++++
 tb/tb_hci_mem_bank_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_mem_bank_responder.sv
// Single-bank memory responder for an HCI-style request/grant port.
// Reads and writes complete in one cycle. A read whose address has TS_BIT set is a
// test-and-set: the old word is returned and all-ones is written in the following
// cycle, with the port closed in between so no other access can slip in.

module hci_mem_bank_responder #(
    parameter int unsigned DW      = 32,
    parameter int unsigned BW      = 8,
    parameter int unsigned AW      = 32,
    parameter int unsigned IW      = 8,
    parameter int unsigned N_WORDS = 256,
    parameter int unsigned TS_BIT  = 21
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [AW-1:0]      add_i,
    input  logic               wen_i,
    input  logic [DW-1:0]      data_i,
    input  logic [DW/BW-1:0]   be_i,
    input  logic [IW-1:0]      id_i,
    input  logic               stall_i,
    output logic [DW-1:0]      r_data_o,
    output logic               r_valid_o,
    output logic [IW-1:0]      r_id_o
);

    localparam int unsigned NB   = DW / BW;
    localparam int unsigned IDXW = $clog2(N_WORDS);

    typedef enum logic [0:0] {
        StIdle,
        StTsWr
    } state_e;

    state_e          state_q;
    logic [IDXW-1:0] ts_idx_q;
    logic [DW-1:0]   r_data_q;
    logic            r_valid_q;
    logic [IW-1:0]   r_id_q;

    logic [DW-1:0]   mem_q [N_WORDS];

    logic [IDXW-1:0] idx;
    logic            hs;
    logic            wr_hs;
    logic            ts_hs;
    logic [DW-1:0]   wr_word;

    // Only the word-index bits and TS_BIT carry meaning; the rest of the address is dropped.
    logic unused_add;
    assign unused_add = ^add_i;

    // Word index wraps modulo N_WORDS; byte offset and upper bits are ignored.
    assign idx   = add_i[IDXW+1:2];

    // Grant is purely combinational and closed while the test-and-set write is pending.
    assign gnt_o = req_i & ~stall_i & (state_q == StIdle);
    assign hs    = req_i & gnt_o;
    assign wr_hs = hs & ~wen_i;
    // TS_BIT only matters for reads; a write with it set is an ordinary write.
    assign ts_hs = hs & wen_i & add_i[TS_BIT];

    // Merge enabled bytes of the write data over the currently stored word.
    always_comb begin
        wr_word = mem_q[idx];
        for (int unsigned k = 0; k < NB; k++) begin
            if (be_i[k]) begin
                wr_word[k*BW +: BW] = data_i[k*BW +: BW];
            end
        end
    end

    // Storage: reset clears every word; the pending all-ones write has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == StTsWr) begin
            mem_q[ts_idx_q] <= '1;
        end else if (wr_hs) begin
            mem_q[idx] <= wr_word;
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ts_idx_q  <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_id_q    <= '0;
        end else begin
            r_valid_q <= hs;
            if (hs) begin
                r_id_q   <= id_i;
                // Reads return the pre-edge word; writes answer with zero data.
                r_data_q <= wen_i ? mem_q[idx] : '0;
            end
            unique case (state_q)
                StIdle: begin
                    if (ts_hs) begin
                        state_q  <= StTsWr;
                        ts_idx_q <= idx;
                    end
                end
                StTsWr: begin
                    // Stall is ignored here so the atomic write always completes.
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign r_data_o  = r_data_q;
    assign r_valid_o = r_valid_q;
    assign r_id_o    = r_id_q;

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Directed bench for hci_mem_bank_responder: inputs change 1ns after the rising edge,
// grant is sampled 1ns later, registered outputs 1ns after the following edge.

module tb_hci_mem_bank_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] add_i;
    logic        wen_i;
    logic [31:0] data_i;
    logic [3:0]  be_i;
    logic [7:0]  id_i;
    logic        stall_i;
    logic [31:0] r_data_o;
    logic        r_valid_o;
    logic [7:0]  r_id_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] TS = 32'h0020_0000;

    always #5 clk_i = ~clk_i;

    hci_mem_bank_responder dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .add_i     (add_i),
        .wen_i     (wen_i),
        .data_i    (data_i),
        .be_i      (be_i),
        .id_i      (id_i),
        .stall_i   (stall_i),
        .r_data_o  (r_data_o),
        .r_valid_o (r_valid_o),
        .r_id_o    (r_id_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic req, input logic wen, input logic [31:0] add,
                         input logic [31:0] data, input logic [3:0] be, input logic [7:0] id);
        req_i  = req;
        wen_i  = wen;
        add_i  = add;
        data_i = data;
        be_i   = be;
        id_i   = id;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'h0);
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        stall_i = 1'b0;
        idle();
        #12;
        n_cmp++;
        if (r_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", r_valid_o); end
        n_cmp++;
        if (r_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", r_data_o); end
        n_cmp++;
        if (r_id_o !== 8'h0) begin n_bad++; $display("FAIL rst_id got %h want 0", r_id_o); end
        step();
        rst_ni = 1'b1;
        drive(1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 8'h0);
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL rst_gnt got %b want 1", gnt_o); end
        idle();
        step();
        step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 8'd3);
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt_wr got %b want 1", gnt_o); end
        step();
        drive(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 8'd4);
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt_rd got %b want 1", gnt_o); end
        n_cmp++;
        if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 8'd3, 32'h0}) begin
            n_bad++;
            $display("FAIL b2b_wr_rsp got v=%b id=%h d=%h want v=1 id=03 d=0",
                     r_valid_o, r_id_o, r_data_o);
        end
        step();
        idle();
        n_cmp++;
        if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 8'd4, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL b2b_rd_rsp got v=%b id=%h d=%h want v=1 id=04 d=deadbeef",
                     r_valid_o, r_id_o, r_data_o);
        end
        step();
        n_cmp++;
        if ({r_valid_o, r_id_o, r_data_o} !== {1'b0, 8'd4, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL b2b_hold got v=%b id=%h d=%h want v=0 id=04 d=deadbeef",
                     r_valid_o, r_id_o, r_data_o);
        end
    endtask

    task automatic test_partial_write();
        drive(1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, 8'd10);
        step();
        drive(1'b1, 1'b0, 32'h20, 32'h000000AA, 4'h1, 8'd11);
        step();
        drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 8'd12);
        step();
        idle();
        n_cmp++;
        if (r_data_o !== 32'h112233AA) begin
            n_bad++; $display("FAIL partial got %h want 112233aa", r_data_o);
        end
        // Upper-byte-only write with TS_BIT set behaves as an ordinary write.
        drive(1'b1, 1'b0, TS | 32'h20, 32'h55000000, 4'h8, 8'd13);
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL ts_wr_gnt got %b want 1", gnt_o); end
        step();
        drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 8'd14);
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL ts_wr_nolock got %b want 1", gnt_o); end
        step();
        idle();
        n_cmp++;
        if (r_data_o !== 32'h552233AA) begin
            n_bad++; $display("FAIL ts_wr_plain got %h want 552233aa", r_data_o);
        end
        step();
    endtask

    task automatic test_test_and_set();
        drive(1'b1, 1'b1, TS | 32'h14, 32'h0, 4'h0, 8'd6);
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL tas_gnt got %b want 1", gnt_o); end
        step();
        drive(1'b1, 1'b1, 32'h14, 32'h0, 4'h0, 8'd7);
        #1;
        n_cmp++;
        if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 8'd6, 32'h0}) begin
            n_bad++;
            $display("FAIL tas_old got v=%b id=%h d=%h want v=1 id=06 d=0",
                     r_valid_o, r_id_o, r_data_o);
        end
        n_cmp++;
        if (gnt_o !== 1'b0) begin n_bad++; $display("FAIL tas_lock got %b want 0", gnt_o); end
        step();
        n_cmp++;
        if (r_valid_o !== 1'b0) begin n_bad++; $display("FAIL tas_gap got %b want 0", r_valid_o); end
        n_cmp++;
        if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL tas_regrant got %b want 1", gnt_o); end
        step();
        idle();
        n_cmp++;
        if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 8'd7, 32'hFFFFFFFF}) begin
            n_bad++;
            $display("FAIL tas_set got v=%b id=%h d=%h want v=1 id=07 d=ffffffff",
                     r_valid_o, r_id_o, r_data_o);
        end
        step();
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        drive(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 8'd9);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if ({gnt_o, r_valid_o} !== 2'b00) begin
                n_bad++;
                $display("FAIL stall_c%0d got gnt=%b v=%b want 0 0", c, gnt_o, r_valid_o);
            end
            step();
        end
        stall_i = 1'b0;
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL stall_release got %b want 1", gnt_o); end
        step();
        idle();
        n_cmp++;
        if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 8'd9, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL stall_rsp got v=%b id=%h d=%h want v=1 id=09 d=deadbeef",
                     r_valid_o, r_id_o, r_data_o);
        end
        step();
    endtask

    task automatic test_alias();
        drive(1'b1, 1'b0, 32'h400, 32'h12345678, 4'hF, 8'd20);
        step();
        drive(1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 8'd21);
        step();
        idle();
        n_cmp++;
        if ({r_id_o, r_data_o} !== {8'd21, 32'h12345678}) begin
            n_bad++;
            $display("FAIL alias got id=%h d=%h want id=15 d=12345678", r_id_o, r_data_o);
        end
        step();
    endtask

    task automatic test_reset_in_ts();
        drive(1'b1, 1'b1, TS | 32'h18, 32'h0, 4'h0, 8'd30);
        step();
        idle();
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (r_valid_o !== 1'b0) begin n_bad++; $display("FAIL tsrst_valid got %b want 0", r_valid_o); end
        #1;
        rst_ni = 1'b1;
        drive(1'b1, 1'b1, 32'h18, 32'h0, 4'h0, 8'd31);
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL tsrst_gnt got %b want 1", gnt_o); end
        step();
        drive(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 8'd32);
        n_cmp++;
        if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 8'd31, 32'h0}) begin
            n_bad++;
            $display("FAIL tsrst_word got v=%b id=%h d=%h want v=1 id=1f d=0",
                     r_valid_o, r_id_o, r_data_o);
        end
        step();
        idle();
        n_cmp++;
        if (r_data_o !== 32'h0) begin n_bad++; $display("FAIL tsrst_clear got %h want 0", r_data_o); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_partial_write();
        test_test_and_set();
        test_stall();
        test_alias();
        test_reset_in_ts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
